// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction-fetch sequencer
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PC_next_clk,
    input  logic             stall,
    input  logic             halt,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      PC,
    output logic [31:0]      PC_plus_4_out,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             misalign
);

    localparam int             TO_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t           state, state_d;
    logic [TO_W-1:0]  to_cnt, to_d;
    logic [31:0]      pc_d;
    logic [31:0]      instr_d;
    logic             req_d;
    logic             valid_d;
    logic             halted_d;
    logic [CNT_W-1:0] cnt_d;

`ifdef PC_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign PC_plus_4_out = PC + 32'd4;
    assign imem_addr     = PC;

    always_comb begin
        state_d  = state;
        to_d     = to_cnt;
        pc_d     = PC;
        instr_d  = instr;
        req_d    = imem_req;
        valid_d  = instr_valid;
        halted_d = halted;
        cnt_d    = retire_cnt;
`ifdef PC_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state)
            S_FETCH: begin
                req_d   = 1'b1;
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end else if (to_cnt == TO_LAST) begin
                    // Drop the request for one cycle, then reissue at the same PC.
                    req_d   = 1'b0;
                    to_d    = '0;
                    state_d = S_FETCH;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    cnt_d   = retire_cnt + CNT_W'(1);
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
`ifdef PC_MISALIGN_TRAP_EN
                        pc_d = PC_next_clk;
                        if (PC_next_clk[1:0] != 2'b00) begin
                            mis_d    = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            req_d   = 1'b1;
                            to_d    = '0;
                            state_d = S_WAIT;
                        end
`else
                        pc_d    = PC_next_clk & 32'hFFFF_FFFC;
                        req_d   = 1'b1;
                        to_d    = '0;
                        state_d = S_WAIT;
`endif
                    end
                end
            end
            S_HALT: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            to_cnt      <= '0;
            PC          <= RESET_PC;
            instr       <= 32'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            retire_cnt  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            to_cnt      <= to_d;
            PC          <= pc_d;
            instr       <= instr_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
            halted      <= halted_d;
            retire_cnt  <= cnt_d;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 4;
    localparam int          CW     = 4;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   PC_next_clk;
    logic          stall;
    logic          halt;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   PC;
    logic [31:0]   PC_plus_4_out;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          halted;
    logic [CW-1:0] retire_cnt;
    logic          misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC   (RST_PC),
        .ACK_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_next_clk  (PC_next_clk),
        .stall        (stall),
        .halt         (halt),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .PC_plus_4_out(PC_plus_4_out),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .retire_cnt   (retire_cnt),
        .misalign     (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the unit holds, not how it sequences.
    logic [31:0] m_pc, m_instr;
    bit          m_valid, m_req, m_halted, m_mis;
    int          m_ret, m_age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RST_PC; m_instr = 32'd0; m_valid = 0; m_req = 0;
            m_halted = 0; m_mis = 0; m_ret = 0; m_age = 0;
        end else if (m_halted) begin
            m_req = 0;
        end else if (m_valid) begin
            if (!stall) begin
                m_ret++;
                m_valid = 0;
                if (halt) begin
                    m_halted = 1;
                end else if (MIS_EN && (PC_next_clk & 32'd3) != 0) begin
                    m_pc = PC_next_clk; m_mis = 1; m_halted = 1;
                end else begin
                    m_pc = PC_next_clk & 32'hFFFF_FFFC; m_req = 1; m_age = 0;
                end
            end
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_valid = 1; m_req = 0;
            end else if (m_age == TO - 1) begin
                m_req = 0;
            end else begin
                m_age++;
            end
        end else begin
            m_req = 1; m_age = 0;
        end
    end

    bit running = 1'b1;

    always @(negedge clk) begin
        if (running) begin
            chk("pc", PC, m_pc);
            chk("pc_plus_4", PC_plus_4_out, m_pc + 32'd4);
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("imem_addr", imem_addr, m_pc);
            chk("instr", instr, m_instr);
            chk("instr_valid", 32'(instr_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("retire_cnt", 32'(retire_cnt), 32'(m_ret & ((1 << CW) - 1)));
            chk("misalign", 32'(misalign), 32'(m_mis));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'd0; PC_next_clk = 32'd0;
        cyc(); cyc();
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_retire", 32'(retire_cnt), 32'd0);

        // Reset release with zero-wait memory
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005; PC_next_clk = 32'd4;
        cyc();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_valid_low", 32'(instr_valid), 32'd0);
        cyc();
        chk("first_instr", instr, 32'h2008_0005);
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential run
        for (int i = 0; i < 6; i++) begin
            imem_rdata  = 32'h1000_0000 + 32'(i);
            PC_next_clk = m_pc + 32'd4;
            cyc();
        end
        chk("seq_pc", PC, 32'hC);
        chk("seq_retire3", 32'(retire_cnt), 32'd3);
        chk("seq_instr", instr, 32'h1000_0005);
        PC_next_clk = m_pc + 32'd4;
        cyc();
        chk("seq_retire4", 32'(retire_cnt), 32'd4);
        chk("seq_pc4", PC, 32'h10);

        // Stall holds the instruction
        imem_rdata = 32'h2222_0000;
        cyc();
        stall = 1'b1; PC_next_clk = 32'h40;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", PC, 32'h10);
        end
        chk("stall_retire", 32'(retire_cnt), 32'd4);
        stall = 1'b0;
        cyc();
        chk("stall_release_pc", PC, 32'h40);
        chk("stall_release_retire", 32'(retire_cnt), 32'd5);

        // Ack timeout: 4 cycles high, 1 low, reissue at same address
        imem_ack = 1'b0;
        chk("to_req_0", 32'(imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_req_high", 32'(imem_req), 32'd1);
        end
        cyc();
        chk("to_req_drop", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("to_reissue", 32'(imem_req), 32'd1);
        chk("to_ack_ignored", 32'(instr_valid), 32'd0);
        chk("to_addr", imem_addr, 32'h40);
        imem_rdata = 32'h1234_5678;
        cyc();
        chk("to_late_ack", instr, 32'h1234_5678);
        chk("to_late_valid", 32'(instr_valid), 32'd1);

        // Halt under stall, then release
        stall = 1'b1; halt = 1'b1;
        cyc(); cyc();
        chk("halt_stalled", 32'(halted), 32'd0);
        stall = 1'b0;
        cyc();
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_retire", 32'(retire_cnt), 32'd6);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("halt_req_low", 32'(imem_req), 32'd0);
        end
        chk("halt_pc", PC, 32'h40);

        // Reset out of HALT, PC wrap and retire counter wrap
        halt = 1'b0; rst = 1'b1;
        #1;
        chk("arst_halted", 32'(halted), 32'd0);
        cyc();
        rst = 1'b0; PC_next_clk = 32'hFFFF_FFFC;
        cyc(); cyc(); cyc();
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_plus_4_out, 32'h0);
        for (int i = 0; i < 32; i++) begin
            PC_next_clk = m_pc + 32'd4;
            cyc();
        end
        chk("wrap_retire", 32'(retire_cnt), 32'd1);
        chk("wrap_pc_end", PC, 32'h3C);

        // Asynchronous reset while waiting
        #2; rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc", PC, RST_PC);
        cyc();
        rst = 1'b0;

        // Misaligned target
        PC_next_clk = 32'h0000_1002;
        cyc(); cyc(); cyc();
        if (MIS_EN) begin
            chk("mis_pc", PC, 32'h0000_1002);
            chk("mis_flag", 32'(misalign), 32'd1);
            chk("mis_halted", 32'(halted), 32'd1);
            chk("mis_req", 32'(imem_req), 32'd0);
        end else begin
            chk("mis_pc", PC, 32'h0000_1000);
            chk("mis_flag", 32'(misalign), 32'd0);
            chk("mis_halted", 32'(halted), 32'd0);
            chk("mis_req", 32'(imem_req), 32'd1);
        end
        chk("mis_retire", 32'(retire_cnt), 32'd1);
        cyc(); cyc();

        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the MIPS core.
- Holds the architectural PC and drives a request/acknowledge fetch from instruction memory at that PC.
- Presents the fetched word to decode and loads the next-address value computed by the next-PC logic once the current instruction is released.
- Sits directly downstream of the next-PC combinational stage and upstream of decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, cycles to wait for imem_ack before dropping and reissuing the request (minimum 2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_next_clk  in  32  next PC from the next-PC stage, sampled on advance.
- stall  in  1  hold the current instruction; no PC advance.
- halt  in  1  current instruction is a halt; stop after it is released.
- imem_ack  in  1  instruction memory has returned data for the current request.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- PC  out  32  current PC, registered.
- PC_plus_4_out  out  32  PC+4, combinational from PC, for link/branch use.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  fetch address, always equals PC.
- instr  out  32  latched instruction word.
- instr_valid  out  1  instr holds the word at PC.
- halted  out  1  unit is in HALT.
- retire_cnt  out  CNT_W  count of instructions released (PC advances plus the halt release).
- misalign  out  1  sticky misaligned-target flag (0 unless PC_MISALIGN_TRAP_EN).

Behaviour:
- Reset (async, rst=1), all outputs at these values while reset is held:
  - PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retire_cnt=0, misalign=0.
  - State=FETCH, timeout counter=0.
  - imem_req rises on the first clock edge after rst deasserts.
- States: FETCH, WAIT, EXEC, HALT.
- FETCH: set imem_req<=1, clear timeout counter, go to WAIT.
- WAIT:
  - imem_req held at 1.
  - imem_ack=1 at an edge: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to EXEC.
  - Otherwise the counter increments. At ACK_TIMEOUT-1 the unit drives imem_req<=0 for exactly one cycle, then returns to FETCH (reissue at the same PC).
  - Any imem_ack while imem_req=0 is ignored.
- EXEC:
  - stall=1: hold everything; stall has priority over halt.
  - stall=0, halt=0: PC<=PC_next_clk, instr_valid<=0, retire_cnt+=1, imem_req<=1, go to WAIT.
  - stall=0, halt=1: PC unchanged, instr_valid<=0, retire_cnt+=1, halted<=1, go to HALT.
- HALT: terminal. imem_req=0 and PC frozen; only rst exits.
- Timing:
  - Throughput with zero-wait memory (ack in the first WAIT cycle) is one instruction per 2 cycles.
  - From the PC-advance edge, instr_valid rises at the edge where ack is first seen.
- Arithmetic:
  - PC_plus_4_out = PC + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - retire_cnt wraps to 0 on overflow.
- Reset mid-fetch: the outstanding request is abandoned immediately. Memory must tolerate imem_req falling without an ack.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: on an EXEC advance with PC_next_clk[1:0]!=0:
  - PC is loaded with the misaligned value (for debug).
  - misalign<=1 and halted<=1; go to HALT with no fetch issued.
  - retire_cnt still increments.
- Not defined: PC<={PC_next_clk[31:2],2'b00} and misalign is tied to 0.

Test Plan:
- Reset release, RESET_PC=0, ack returns 32'h2008_0005 in the first WAIT cycle -> imem_addr=0, instr=32'h2008_0005, instr_valid=1 two edges after reset.
- Sequential run, PC_next_clk=PC+4, zero-wait memory, 4 instructions -> PC steps 0,4,8,C; retire_cnt=4; instr_valid pulses every 2 cycles.
- stall held 3 cycles in EXEC with PC_next_clk=32'h40 -> PC stays 0 for 3 cycles, then becomes 32'h40; retire_cnt increments only once.
- ACK_TIMEOUT=4, no ack -> imem_req high 4 cycles, low 1 cycle, high again at the same imem_addr; a later ack is then accepted normally.
- halt=1 with stall=1 for 2 cycles, then stall=0 -> halted=1 one edge after stall drops; PC frozen; imem_req stays 0 for 10+ cycles.
- PC_next_clk=32'h0000_1002 -> PC=32'h0000_1000 without the macro; with PC_MISALIGN_TRAP_EN, PC=32'h0000_1002, misalign=1, halted=1. Also assert rst mid-WAIT -> PC=RESET_PC and imem_req=0 asynchronously.
